// File: rtl/branch_predict_ctrl.sv
// Branch predictor: 2-bit saturating-counter BHT plus an in-flight prediction FIFO that flags mispredicts.
// Optional per-run statistics counters are enabled by defining BRANCH_PREDICT_STATS_EN.
module branch_predict_ctrl #(
  parameter int          ADDR_W   = 32,
  parameter int          IDX_W    = 4,
  parameter int          DEPTH    = 4,
  parameter logic [1:0]  BHT_INIT = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_is_branch,
  input  logic [ADDR_W-1:0] if_target,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  input  logic              res_valid,
  input  logic              res_is_branch,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic [ADDR_W-1:0] res_next_pc,
  input  logic [ADDR_W-1:0] res_seq_pc,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              fifo_err
`ifdef BRANCH_PREDICT_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

  logic [1:0]        bht_q [ENTRIES];
  logic [1:0]        bht_d [ENTRIES];
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fifo_err_q, fifo_err_d;

  logic [IDX_W-1:0]  if_idx, res_idx;
  logic [1:0]        if_ctr, res_ctr;
  logic              empty, full, push_req, pop_req, push_ok, pop_ok;
  logic              bht_upd, res_taken;
  logic              unused_res_pc;

  assign if_idx        = if_pc[IDX_W+1:2];
  assign res_idx       = res_pc[IDX_W+1:2];
  assign unused_res_pc = ^{res_pc[ADDR_W-1:IDX_W+2], res_pc[1:0]};
  assign if_ctr        = bht_q[if_idx];
  assign res_ctr       = bht_q[res_idx];

  assign pred_taken   = if_is_branch & if_ctr[1];
  assign pred_next_pc = pred_taken ? if_target : (if_pc + PC_INC);

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign pop_req  = res_valid & ~stall;
  assign flush    = pop_req & ~empty & (mem_q[rd_ptr_q] != res_next_pc);
  assign push_req = if_valid & ~stall & ~flush;
  assign pop_ok   = pop_req & ~empty;
  assign push_ok  = push_req & (~full | pop_ok);

  assign redirect_pc = flush ? res_next_pc : '0;
  assign fifo_err    = fifo_err_q;

  // A flush discards every in-flight entry, including a same-cycle push from the wrong path.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fifo_err_d = fifo_err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if ((push_req & ~push_ok) | (pop_req & empty)) fifo_err_d = 1'b1;
      if (push_ok) begin
        mem_d[wr_ptr_q] = pred_next_pc;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  assign bht_upd   = pop_req & res_is_branch;
  assign res_taken = (res_next_pc != res_seq_pc);

  always_comb begin
    bht_d = bht_q;
    if (bht_upd) begin
      if (res_taken && (res_ctr != 2'b11))
        bht_d[res_idx] = res_ctr + 2'b01;
      else if (!res_taken && (res_ctr != 2'b00))
        bht_d[res_idx] = res_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= BHT_INIT;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fifo_err_q <= 1'b0;
    end else begin
      bht_q      <= bht_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fifo_err_q <= fifo_err_d;
    end
  end

`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Both event conditions already exclude stall, so the counters freeze with the pipeline.
  always_comb begin
    stat_branches_d    = stat_branches_q + 32'(bht_upd);
    stat_mispredicts_d = stat_mispredicts_q + 32'(flush);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed self-checking bench for branch_predict_ctrl (default parameters).
// Stats outputs are connected and checked when BRANCH_PREDICT_STATS_EN is defined.
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_is_branch;
  logic [31:0] if_target;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        res_valid;
  logic        res_is_branch;
  logic [31:0] res_pc;
  logic [31:0] res_next_pc;
  logic [31:0] res_seq_pc;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        fifo_err;
`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int checks   = 0;
  int failures = 0;

  branch_predict_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_is_branch  (if_is_branch),
    .if_target     (if_target),
    .pred_taken    (pred_taken),
    .pred_next_pc  (pred_next_pc),
    .res_valid     (res_valid),
    .res_is_branch (res_is_branch),
    .res_pc        (res_pc),
    .res_next_pc   (res_next_pc),
    .res_seq_pc    (res_seq_pc),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .fifo_err      (fifo_err)
`ifdef BRANCH_PREDICT_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall         = 1'b0;
    if_valid      = 1'b0;
    if_pc         = 32'h0;
    if_is_branch  = 1'b0;
    if_target     = 32'h0;
    res_valid     = 1'b0;
    res_is_branch = 1'b0;
    res_pc        = 32'h0;
    res_next_pc   = 32'h0;
    res_seq_pc    = 32'h0;
  endtask

  task automatic fetch(input logic valid, input logic [31:0] pc, input logic br, input logic [31:0] tgt);
    if_valid     = valid;
    if_pc        = pc;
    if_is_branch = br;
    if_target    = tgt;
  endtask

  task automatic resolve(input logic br, input logic [31:0] pc, input logic [31:0] nxt);
    res_valid     = 1'b1;
    res_is_branch = br;
    res_pc        = pc;
    res_next_pc   = nxt;
    res_seq_pc    = pc + 32'd4;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush: got %b want 0", flush); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect: got %h want 0", redirect_pc); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken); end
    checks++; if (fifo_err !== 1'b0) begin failures++; $display("FAIL reset_fifo_err: got %b want 0", fifo_err); end
    checks++; if (dut.count_q !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", dut.count_q); end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_predict();
    fetch(1'b1, 32'h40, 1'b1, 32'h80);
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL predict_taken: got %b want 0", pred_taken); end
    checks++; if (pred_next_pc !== 32'h44) begin failures++; $display("FAIL predict_next: got %h want 44", pred_next_pc); end
    tick();
    idle();
    #1;
    checks++; if (dut.count_q !== 3'd1) begin failures++; $display("FAIL predict_count: got %0d want 1", dut.count_q); end
  endtask

  task automatic test_mispredict();
    fetch(1'b1, 32'h40, 1'b1, 32'h80);
    resolve(1'b1, 32'h40, 32'h80);
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL mispredict_flush: got %b want 1", flush); end
    checks++; if (redirect_pc !== 32'h80) begin failures++; $display("FAIL mispredict_redirect: got %h want 80", redirect_pc); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL same_cycle_pred: got %b want 0", pred_taken); end
    tick();
    idle();
    #1;
    checks++; if (dut.count_q !== 3'd0) begin failures++; $display("FAIL mispredict_count: got %0d want 0", dut.count_q); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL flush_one_cycle: got %b want 0", flush); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL redirect_idle: got %h want 0", redirect_pc); end
    fetch(1'b0, 32'h40, 1'b1, 32'h80);
    #1;
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL refetch_taken: got %b want 1", pred_taken); end
    checks++; if (pred_next_pc !== 32'h80) begin failures++; $display("FAIL refetch_next: got %h want 80", pred_next_pc); end
  endtask

  task automatic test_saturate();
    // counter at 10: three taken resolves go 11,11,11 and never mispredict
    for (int i = 0; i < 3; i++) begin
      idle();
      fetch(1'b1, 32'h40, 1'b1, 32'h80);
      #1;
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_pred_%0d: got %b want 1", i, pred_taken); end
      tick();
      idle();
      resolve(1'b1, 32'h40, 32'h80);
      #1;
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL sat_flush_%0d: got %b want 0", i, flush); end
      tick();
    end
    // two not-taken resolves: 11 -> 10 (still taken) -> 01 (not taken)
    for (int j = 0; j < 2; j++) begin
      idle();
      fetch(1'b1, 32'h40, 1'b1, 32'h80);
      tick();
      idle();
      resolve(1'b1, 32'h40, 32'h44);
      #1;
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL nt_flush_%0d: got %b want 1", j, flush); end
      checks++; if (redirect_pc !== 32'h44) begin failures++; $display("FAIL nt_redirect_%0d: got %h want 44", j, redirect_pc); end
      tick();
      idle();
      fetch(1'b0, 32'h40, 1'b1, 32'h80);
      #1;
      checks++; if (pred_taken !== (j == 0)) begin failures++; $display("FAIL nt_pred_%0d: got %b want %b", j, pred_taken, (j == 0)); end
    end
    idle();
  endtask

  task automatic test_overflow();
    logic [31:0] expect_head [4];
    expect_head[0] = 32'h108;
    expect_head[1] = 32'h10c;
    expect_head[2] = 32'h110;
    expect_head[3] = 32'h204;
    idle();
    for (int i = 0; i < 5; i++) begin
      fetch(1'b1, 32'h100 + 32'(4 * i), 1'b0, 32'h0);
      tick();
      if (i == 3) begin
        checks++; if (fifo_err !== 1'b0) begin failures++; $display("FAIL full_no_err: got %b want 0", fifo_err); end
      end
    end
    idle();
    #1;
    checks++; if (dut.count_q !== 3'd4) begin failures++; $display("FAIL overflow_count: got %0d want 4", dut.count_q); end
    checks++; if (fifo_err !== 1'b1) begin failures++; $display("FAIL overflow_err: got %b want 1", fifo_err); end
    fetch(1'b1, 32'h200, 1'b0, 32'h0);
    resolve(1'b0, 32'h100, 32'h104);
    #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL full_pushpop_flush: got %b want 0", flush); end
    tick();
    idle();
    #1;
    checks++; if (dut.count_q !== 3'd4) begin failures++; $display("FAIL full_pushpop_count: got %0d want 4", dut.count_q); end
    for (int k = 0; k < 4; k++) begin
      resolve(1'b0, 32'h0, expect_head[k]);
      #1;
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL drain_order_%0d: flush got %b want 0 (next %h)", k, flush, expect_head[k]); end
      tick();
    end
    idle();
    #1;
    checks++; if (dut.count_q !== 3'd0) begin failures++; $display("FAIL drain_count: got %0d want 0", dut.count_q); end
  endtask

  task automatic test_empty_pop();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (fifo_err !== 1'b0) begin failures++; $display("FAIL err_cleared: got %b want 0", fifo_err); end
    resolve(1'b0, 32'h0, 32'h500);
    #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL empty_pop_flush: got %b want 0", flush); end
    tick();
    idle();
    #1;
    checks++; if (fifo_err !== 1'b1) begin failures++; $display("FAIL empty_pop_err: got %b want 1", fifo_err); end
    checks++; if (dut.count_q !== 3'd0) begin failures++; $display("FAIL empty_pop_count: got %0d want 0", dut.count_q); end
  endtask

  task automatic test_stall();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fetch(1'b1, 32'h40, 1'b1, 32'h80);
    #1;
    checks++; if (pred_next_pc !== 32'h44) begin failures++; $display("FAIL stall_setup_next: got %h want 44", pred_next_pc); end
    tick();
    idle();
    stall = 1'b1;
    fetch(1'b1, 32'h300, 1'b0, 32'h0);
    resolve(1'b1, 32'h40, 32'h80);
    #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL stall_flush: got %b want 0", flush); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL stall_redirect: got %h want 0", redirect_pc); end
    tick();
    tick();
    checks++; if (dut.count_q !== 3'd1) begin failures++; $display("FAIL stall_count: got %0d want 1", dut.count_q); end
    fetch(1'b1, 32'h40, 1'b1, 32'h80);
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL stall_bht: got %b want 0", pred_taken); end
    stall = 1'b0;
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL unstall_flush: got %b want 1", flush); end
    checks++; if (redirect_pc !== 32'h80) begin failures++; $display("FAIL unstall_redirect: got %h want 80", redirect_pc); end
    tick();
    idle();
    fetch(1'b0, 32'h40, 1'b1, 32'h80);
    #1;
    checks++; if (dut.count_q !== 3'd0) begin failures++; $display("FAIL unstall_count: got %0d want 0", dut.count_q); end
    checks++; if (fifo_err !== 1'b0) begin failures++; $display("FAIL unstall_err: got %b want 0", fifo_err); end
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL unstall_pred: got %b want 1", pred_taken); end
  endtask

  task automatic test_reset_mid_flush();
    idle();
    fetch(1'b1, 32'h40, 1'b1, 32'h80);
    tick();
    idle();
    resolve(1'b1, 32'h40, 32'h44);
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL midflush_pre: got %b want 1", flush); end
    reset = 1'b1;
    #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL midflush_flush: got %b want 0", flush); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL midflush_redirect: got %h want 0", redirect_pc); end
    checks++; if (dut.count_q !== 3'd0) begin failures++; $display("FAIL midflush_count: got %0d want 0", dut.count_q); end
`ifdef BRANCH_PREDICT_STATS_EN
    checks++; if (stat_mispredicts !== 32'h0) begin failures++; $display("FAIL midflush_stat: got %0d want 0", stat_mispredicts); end
    checks++; if (stat_branches !== 32'h0) begin failures++; $display("FAIL midflush_stat_br: got %0d want 0", stat_branches); end
`endif
    tick();
    reset = 1'b0;
    idle();
    fetch(1'b0, 32'h40, 1'b1, 32'h80);
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL midflush_bht: got %b want 0", pred_taken); end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_predict();
    test_mispredict();
    test_saturate();
    test_overflow();
    test_empty_pop();
    test_stall();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
